alu_sequencer: RTL
==================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits; legal values are 8 to 64.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  synchronous, active-low reset.
REQ-004 start  input  1  request strobe; sampled only when busy=0.
REQ-005 ALUControl  input  3  operation code:
- 010 add
- 110 sub
- 000 and
- 001 or
- 111 slt
- 011 mul
REQ-006 SrcA  input  WIDTH  first operand.
REQ-007 SrcB  input  WIDTH  second operand.
REQ-008 busy  output  1  high while a multiply is iterating; the core stalls on it.
REQ-009 done  output  1  one-cycle pulse when Result is updated.
REQ-010 Result  output  WIDTH  registered result; the low product half for mul.
REQ-011 ResultHi  output  WIDTH  high product half for mul; 0 for all other operations.
REQ-012 Zero  output  1  registered (Result==0), updated together with Result.
REQ-013 err  output  1  registered; set to 1 with done for an illegal code (100, 101), else 0.

Function
REQ-014 FSM states SHALL be IDLE, MUL and DONE; reset state is IDLE.
REQ-015 A start is accepted in IDLE or DONE when start=1 and busy=0; start while busy=1 SHALL be ignored and not queued.
REQ-016 Non-mul code accepted at edge N:
- Result, Zero and err are loaded at edge N.
- The state goes to DONE.
- done=1 during cycle N+1.
- busy stays 0.
- Latency is 1 cycle.
REQ-017 Arithmetic rules:
- add/sub wrap modulo 2^WIDTH; no overflow flag.
- slt is a signed two's-complement compare and gives Result = 0 or 1.
- and/or are bitwise.
REQ-018 Illegal code: Result=0, ResultHi=0, Zero=1, err=1, done pulse after 1 cycle.
REQ-019 mul accepted at edge N:
- SrcA and SrcB are latched.
- A 2*WIDTH accumulator is cleared.
- The iteration counter is loaded with WIDTH.
- The state goes to MUL.
- busy=1 from cycle N+1.
REQ-020 In MUL, each cycle performs one shift-add step, adding the shifted multiplicand when the current multiplier LSB is 1, and decrements the counter.
- After WIDTH iterations, Result/ResultHi/Zero are loaded and the state goes to DONE.
- busy=1 for exactly WIDTH cycles.
- done=1 in cycle N+WIDTH+1.
REQ-021 Zero for mul SHALL reflect the low half only.
REQ-022 In DONE, done=1 for one cycle.
- Without a new start, the next state is IDLE.
- With start=1, the new operation is accepted (back-to-back), so done may be high on consecutive cycles.
REQ-023 Result, ResultHi, Zero and err SHALL hold their values until the next done pulse.
REQ-024 SrcA, SrcB and ALUControl changes during MUL SHALL NOT affect the operation in progress.

Reset
REQ-025 When reset_n=0 at a rising edge, the block SHALL reset: state IDLE, busy=0, done=0, Result=0, ResultHi=0, Zero=0, err=0, counter and accumulator 0.
REQ-026 Reset during MUL SHALL abort the operation with no done pulse.
- A start sampled in the same cycle as reset is discarded.
- The first start is accepted at the first edge with reset_n=1.

Configuration
REQ-027 Macro ALU_SEQ_SIGNED_MUL_EN:
- Defined: mul treats SrcA/SrcB as two's complement. The block multiplies the magnitudes and negates the 2*WIDTH product when the operand signs differ, with no extra cycles.
- Undefined: mul is unsigned.
- slt is signed in both builds.

Verification
REQ-028 add: SrcA=5, SrcB=7, start one cycle -> next cycle done=1, Result=12, Zero=0, busy never 1.
REQ-029 sub: SrcA=SrcB=0x1234 -> Result=0, Zero=1; slt: SrcA=0xFFFFFFFF, SrcB=1 -> Result=1.
REQ-030 mul, WIDTH=32: SrcA=0xFFFFFFFF, SrcB=2 ->
- busy high for exactly 32 cycles, done in cycle N+33.
- Unsigned build: ResultHi=1, Result=0xFFFFFFFE.
- Signed build: ResultHi=0xFFFFFFFF, Result=0xFFFFFFFE.
REQ-031 During mul, pulse start with an add and change the operands -> the add is ignored and the product is unchanged; an add issued in the mul DONE cycle gives done on the next cycle.
REQ-032 Reset mid-mul:
- Stimulus: assert reset_n=0 at iteration 10, then start add 1+1.
- Required: no done pulse from the aborted mul, all outputs 0, then Result=2 one cycle after the start.
- Illegal code 100 -> err=1, Result=0, Zero=1.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer: single-cycle ALU (add/sub/and/or/slt) plus a WIDTH-cycle
// shift-add multiplier sequenced by a three-state FSM (IDLE, MUL, DONE).
// Optional feature macro: ALU_SEQ_SIGNED_MUL_EN selects a signed multiply
// (sign-magnitude around the unsigned shift-add core). When it is undefined,
// the multiply is unsigned. slt is signed in both builds.
module alu_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       ALUControl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result,
    output logic [WIDTH-1:0] ResultHi,
    output logic             Zero,
    output logic             err
);

    localparam int CW = $clog2(WIDTH + 1);

`ifdef ALU_SEQ_SIGNED_MUL_EN
    localparam bit SIGNED_MUL = 1'b1;
`else
    localparam bit SIGNED_MUL = 1'b0;
`endif

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic               neg;

    logic               accept;
    logic               is_mul;
    logic               last_step;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_err;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               a_neg, b_neg;
    logic [2*WIDTH-1:0] acc_sum;
    logic [2*WIDTH-1:0] prod;

    // A request is only taken when no multiply is iterating.
    assign accept    = start && (state != MUL);
    assign is_mul    = (ALUControl == OP_MUL);
    assign last_step = (state == MUL) && (cnt == CW'(1));

    // Operand magnitudes: the iterative core is always unsigned, so in the
    // signed build negative operands are negated here and the sign is
    // reapplied to the full product on the final step. The most negative
    // value negates to itself, which as unsigned is its correct magnitude.
    assign a_neg = SIGNED_MUL && SrcA[WIDTH-1];
    assign b_neg = SIGNED_MUL && SrcB[WIDTH-1];
    assign a_mag = a_neg ? (~SrcA + WIDTH'(1)) : SrcA;
    assign b_mag = b_neg ? (~SrcB + WIDTH'(1)) : SrcB;

    // One shift-add step; the final product includes the last step's addend.
    assign acc_sum = acc + (mplier[0] ? mcand : '0);
    assign prod    = neg ? (~acc_sum + (2*WIDTH)'(1)) : acc_sum;

    // Single-cycle operations; illegal codes produce a zero result with err.
    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        case (ALUControl)
            OP_ADD:  alu_res = SrcA + SrcB;
            OP_SUB:  alu_res = SrcA - SrcB;
            OP_AND:  alu_res = SrcA & SrcB;
            OP_OR:   alu_res = SrcA | SrcB;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            OP_MUL:  alu_res = '0;
            default: alu_err = 1'b1;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic. busy and done are decoded from the current state.
    always_comb begin
        state_nxt = state;
        busy      = (state == MUL);
        done      = (state == DONE);
        case (state)
            IDLE: begin
                if (accept) state_nxt = is_mul ? MUL : DONE;
            end
            MUL: begin
                if (last_step) state_nxt = DONE;
            end
            DONE: begin
                if (accept) state_nxt = is_mul ? MUL : DONE;
                else        state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand latching, iteration and result registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt      <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            neg      <= 1'b0;
            Result   <= '0;
            ResultHi <= '0;
            Zero     <= 1'b0;
            err      <= 1'b0;
        end else if (accept) begin
            if (is_mul) begin
                mcand  <= {{WIDTH{1'b0}}, a_mag};
                mplier <= b_mag;
                neg    <= a_neg ^ b_neg;
                acc    <= '0;
                cnt    <= CW'(WIDTH);
            end else begin
                Result   <= alu_res;
                ResultHi <= '0;
                Zero     <= (alu_res == '0);
                err      <= alu_err;
            end
        end else if (state == MUL) begin
            acc    <= acc_sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CW'(1);
            if (last_step) begin
                Result   <= prod[WIDTH-1:0];
                ResultHi <= prod[2*WIDTH-1:WIDTH];
                Zero     <= (prod[WIDTH-1:0] == '0);
                err      <= 1'b0;
            end
        end
    end

endmodule
